// File: rtl/ecg_decim_conditioner.sv
// ECG conditioner: rounds and clamps the FIR accumulator to 16 bits, decimates by DECIM, and buffers the result in a FWFT FIFO.
// Define ECG_SAT_COUNT_EN to add the 16-bit saturating sat_count output.
module ecg_decim_conditioner #(
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [40:0]            din,
    input  logic                          din_valid,
    output logic signed [15:0]            dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          sat_pulse
`ifdef ECG_SAT_COUNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;

    // Stage 1 arithmetic: one guard bit keeps the rounding add from overflowing.
    logic signed [41:0] din_ext;
    logic signed [41:0] rnd_sum;
    logic signed [41:0] shifted;
    logic               sat_hi;
    logic               sat_lo;
    logic signed [15:0] clamped;

    assign din_ext = {din[40], din};
    assign rnd_sum = din_ext + (42'sd1 <<< (SHIFT - 1));
    assign shifted = rnd_sum >>> SHIFT;
    assign sat_hi  = (shifted > 42'sd32767);
    assign sat_lo  = (shifted < -42'sd32768);

    always_comb begin
        clamped = shifted[15:0];
        if (sat_hi) begin
            clamped = 16'sh7fff;
        end else if (sat_lo) begin
            clamped = 16'sh8000;
        end
    end

    logic signed [15:0] s1_data_q, s1_data_d;
    logic               fwd_q, fwd_d;
    logic               sat_q, sat_d;
    logic [PH_W-1:0]    phase_q, phase_d;

    always_comb begin
        s1_data_d = s1_data_q;
        fwd_d     = 1'b0;
        sat_d     = 1'b0;
        phase_d   = phase_q;
        if (din_valid) begin
            s1_data_d = clamped;
            fwd_d     = (phase_q == '0);
            sat_d     = sat_hi | sat_lo;
            phase_d   = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_data_q <= '0;
            fwd_q     <= 1'b0;
            sat_q     <= 1'b0;
            phase_q   <= '0;
        end else begin
            s1_data_q <= s1_data_d;
            fwd_q     <= fwd_d;
            sat_q     <= sat_d;
            phase_q   <= phase_d;
        end
    end

    logic signed [15:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;

    assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & dout_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign push       = fwd_q & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
        ovf_d = ovf_q | (fwd_q & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    // Head is masked to zero while empty so stale storage never shows.
    assign dout       = fifo_empty ? 16'sd0 : mem_q[rd_ptr_q];
    assign dout_valid = ~fifo_empty;
    assign fifo_level = count_q;
    assign overflow   = ovf_q;
    assign sat_pulse  = sat_q;

`ifdef ECG_SAT_COUNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else if (sat_q && (sat_cnt_q != 16'hffff)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ecg_decim_conditioner.sv
// Bench for ecg_decim_conditioner: a DECIM=4 and a DECIM=1 instance share stimulus and are compared every cycle
// against a queue-based reference model, plus directed checks of the documented example vectors.
module tb_ecg_decim_conditioner;

    localparam int SHIFT = 15;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [40:0] din;
    logic               din_valid;
    logic               dout_ready;

    logic signed [15:0] dout0, dout1;
    logic               dv0, dv1;
    logic [3:0]         lvl0, lvl1;
    logic               ovf0, ovf1;
    logic               sp0, sp1;
`ifdef ECG_SAT_COUNT_EN
    logic [15:0]        sc0, sc1;
`endif

    ecg_decim_conditioner #(.SHIFT(SHIFT), .DECIM(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout0),
        .dout_valid (dv0),
        .dout_ready (dout_ready),
        .fifo_level (lvl0),
        .overflow   (ovf0),
        .sat_pulse  (sp0)
`ifdef ECG_SAT_COUNT_EN
        ,
        .sat_count  (sc0)
`endif
    );

    ecg_decim_conditioner #(.SHIFT(SHIFT), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout1),
        .dout_valid (dv1),
        .dout_ready (dout_ready),
        .fifo_level (lvl1),
        .overflow   (ovf1),
        .sat_pulse  (sp1)
`ifdef ECG_SAT_COUNT_EN
        ,
        .sat_count  (sc1)
`endif
    );

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: per-instance queue of stored samples plus the sample awaiting its FIFO write.
    int  mq [2][$];
    bit  m_pend [2];
    int  m_pval [2];
    int  m_nsamp [2];
    bit  m_ovf [2];
    bit  m_sat;
    int  m_satcnt;

    function automatic int decim_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Round half up via floor division, independent of any shift operator.
    function automatic longint model_round(input longint v);
        longint den, num, q;
        den = longint'(1) << SHIFT;
        num = v + den / 2;
        q   = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_step();
        longint r;
        bit     clip;
        bit     pop;
        bit     full;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_pend[i]  = 1'b0;
                m_nsamp[i] = 0;
                m_ovf[i]   = 1'b0;
            end
            m_sat    = 1'b0;
            m_satcnt = 0;
            return;
        end
        if (m_sat && m_satcnt < 65535) m_satcnt++;
        r    = model_round(longint'(din));
        clip = (r > 32767) || (r < -32768);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        for (int i = 0; i < 2; i++) begin
            pop  = (mq[i].size() > 0) && dout_ready;
            full = (mq[i].size() == DEPTH);
            if (pop) void'(mq[i].pop_front());
            if (m_pend[i]) begin
                if (full && !pop) m_ovf[i] = 1'b1;
                else mq[i].push_back(m_pval[i]);
            end
            if (din_valid) begin
                m_pend[i]  = ((m_nsamp[i] % decim_of(i)) == 0);
                m_pval[i]  = int'(r);
                m_nsamp[i] = m_nsamp[i] + 1;
            end else begin
                m_pend[i] = 1'b0;
            end
        end
        m_sat = din_valid && clip;
    endtask

    task automatic compare_all();
        longint exp_dout;
        for (int i = 0; i < 2; i++) begin
            exp_dout = (mq[i].size() > 0) ? longint'(mq[i][0]) : 0;
            check($sformatf("i%0d.dout_valid", i), longint'(i == 0 ? dv0 : dv1), longint'(mq[i].size() > 0));
            check($sformatf("i%0d.dout", i), i == 0 ? longint'(dout0) : longint'(dout1), exp_dout);
            check($sformatf("i%0d.fifo_level", i), longint'(i == 0 ? lvl0 : lvl1), longint'(mq[i].size()));
            check($sformatf("i%0d.overflow", i), longint'(i == 0 ? ovf0 : ovf1), longint'(m_ovf[i]));
            check($sformatf("i%0d.sat_pulse", i), longint'(i == 0 ? sp0 : sp1), longint'(m_sat));
`ifdef ECG_SAT_COUNT_EN
            check($sformatf("i%0d.sat_count", i), longint'(i == 0 ? sc0 : sc1), longint'(m_satcnt));
`endif
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_all();
    end

    // Observed pops and saturation pulses, sampled mid-cycle.
    int cap0 [$];
    int cap1 [$];
    int sat_seen;
    always @(negedge clk) begin
        if (dv0 && dout_ready) cap0.push_back(int'(dout0));
        if (dv1 && dout_ready) cap1.push_back(int'(dout1));
        if (sp1) sat_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input longint x);
        din_valid = v;
        din       = x[40:0];
        tick();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        tick();
        rst = 1'b1;
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        check({tag, ".count"}, longint'(got.size()), longint'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), longint'(got[i]), longint'(exp[i]));
        end
    endtask

    initial begin
        int     exp_q [$];
        longint v;
        int     mode;

        rst        = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        sat_seen   = 0;
        tick();
        tick();
        rst = 1'b1;
        check("reset.dout_valid", longint'(dv0), 0);
        check("reset.fifo_level", longint'(lvl0), 0);
        check("reset.overflow", longint'(ovf0), 0);
        check("reset.sat_pulse", longint'(sp0), 0);
        check("reset.dout", longint'(dout0), 0);
        $display("[TB] reset state checked");

        // Rounding at the half-LSB boundaries, every sample forwarded.
        do_reset();
        dout_ready = 1'b1;
        cap1.delete();
        drive(1, 32768);
        drive(1, 16384);
        drive(1, -16384);
        drive(1, -16385);
        repeat (3) drive(0, 0);
        exp_q = '{1, 1, 0, -1};
        check_list("round", cap1, exp_q);
        $display("[TB] rounding vectors: %0d samples popped", cap1.size());

        // Saturation at both rails.
        do_reset();
        cap1.delete();
        sat_seen = 0;
        drive(1, (longint'(1) << 40) - 1);
        drive(1, -(longint'(1) << 40));
        repeat (3) drive(0, 0);
        exp_q = '{32767, -32768};
        check_list("sat", cap1, exp_q);
        check("sat.pulses", longint'(sat_seen), 2);
`ifdef ECG_SAT_COUNT_EN
        check("sat.count", longint'(sc1), 2);
`endif
        $display("[TB] saturation vectors: %0d pulses seen", sat_seen);

        // Decimation by 4 and two-edge latency.
        do_reset();
        cap0.delete();
        drive(1, 0);
        check("lat.edge1_valid", longint'(dv0), 0);
        drive(1, 32768);
        check("lat.edge2_valid", longint'(dv0), 1);
        check("lat.edge2_dout", longint'(dout0), 0);
        for (int k = 2; k < 16; k++) drive(1, longint'(k) * 32768);
        repeat (3) drive(0, 0);
        exp_q = '{0, 4, 8, 12};
        check_list("decim", cap0, exp_q);
        $display("[TB] decimation: %0d samples popped", cap0.size());

        // Overflow with the consumer stalled, then drain in order.
        do_reset();
        dout_ready = 1'b0;
        for (int k = 0; k < 40; k++) drive(1, longint'(k) * 32768);
        repeat (2) drive(0, 0);
        check("ovf.level", longint'(lvl0), 8);
        check("ovf.flag", longint'(ovf0), 1);
        cap0.delete();
        dout_ready = 1'b1;
        repeat (10) drive(0, 0);
        exp_q = '{0, 4, 8, 12, 16, 20, 24, 28};
        check_list("ovf.drain", cap0, exp_q);
        check("ovf.sticky", longint'(ovf0), 1);
        $display("[TB] overflow: drained %0d samples", cap0.size());

        // Full FIFO, write and pop on the same edge.
        do_reset();
        dout_ready = 1'b0;
        for (int k = 0; k < 32; k++) drive(1, longint'(k) * 32768);
        drive(0, 0);
        check("fullpop.pre_level", longint'(lvl0), 8);
        check("fullpop.pre_ovf", longint'(ovf0), 0);
        drive(1, longint'(32) * 32768);
        dout_ready = 1'b1;
        drive(0, 0);
        dout_ready = 1'b0;
        check("fullpop.level", longint'(lvl0), 8);
        check("fullpop.ovf", longint'(ovf0), 0);
        check("fullpop.head", longint'(dout0), 4);
        $display("[TB] full with pop: level %0d", lvl0);

        // Reset mid-stream with the phase counter away from zero.
        do_reset();
        dout_ready = 1'b0;
        for (int k = 0; k < 18; k++) drive(1, longint'(k) * 32768);
        drive(0, 0);
        check("midrst.pre_level", longint'(lvl0), 5);
        do_reset();
        check("midrst.level", longint'(lvl0), 0);
        check("midrst.valid", longint'(dv0), 0);
        check("midrst.ovf1", longint'(ovf1), 0);
        dout_ready = 1'b1;
        drive(1, longint'(7) * 32768);
        drive(0, 0);
        check("midrst.first_valid", longint'(dv0), 1);
        check("midrst.first_dout", longint'(dout0), 7);
        $display("[TB] mid-stream reset: first sample %0d", dout0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 99) != 0);
            din_valid  = ($urandom_range(0, 9) < 7);
            dout_ready = $urandom_range(0, 1) == 1;
            mode = $urandom_range(0, 3);
            case (mode)
                0: v = longint'($urandom_range(0, 2000000)) - 1000000;
                1: v = longint'($signed($urandom)) * 300;
                2: v = ($urandom_range(0, 1) == 1) ? (longint'(1) << 40) - 1 : -(longint'(1) << 40);
                default: v = (longint'($urandom_range(0, 200)) - 100) * 32768 + 16384
                             - longint'($urandom_range(0, 1));
            endcase
            din = v[40:0];
            tick();
        end
        rst = 1'b1;
        $display("[TB] random traffic: 1500 cycles");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
